selecteur_type_de: RTL and testbench
====================================

SELECTEUR_TYPE_DE -- requirements
Module: selecteur_type_de

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of consecutive stable clk cycles before a button level is accepted.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000, meaning the auto-repeat period while a button is held; used only under REQ-024.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port btnSuiv, input, 1, raw asynchronous "next die" push button, active-high.
REQ-006 SHALL have port btnPrec, input, 1, raw asynchronous "previous die" push button, active-high.
REQ-007 SHALL have port dMin, output, 7, lowest face value of the selected die.
REQ-008 SHALL have port dMax, output, 7, highest face value of the selected die.
REQ-009 SHALL have port changement, output, 1, one-cycle pulse when the selection changes.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-011 SHALL debounce each synchronized button independently: the accepted level updates only after DEBOUNCE_CYCLES consecutive cycles in which the synchronized level differs from the accepted level; any intermediate return to the accepted level SHALL restart the count from 0.
REQ-012 SHALL size the debounce counter as clog2(DEBOUNCE_CYCLES+1) bits; the counter SHALL saturate and never wrap.
REQ-013 SHALL generate a press event on the cycle in which an accepted level goes 0->1; a 1->0 transition generates no event.
REQ-014 SHALL hold a 7-state FSM: D4, D6, D8, D10, D12, D20, D100, ordered as listed.
REQ-015 On a btnSuiv event alone, the FSM SHALL advance one state; D100 wraps to D4.
REQ-016 On a btnPrec event alone, the FSM SHALL move back one state; D4 wraps to D100.
REQ-017 On btnSuiv and btnPrec events in the same cycle, the FSM SHALL hold state and changement SHALL stay 0.
REQ-018 SHALL drive dMin=1 in every state and dMax=4,6,8,10,12,20,100 for D4..D100 respectively; both outputs are registered.
REQ-019 SHALL update dMin/dMax exactly one cycle after the press-event cycle, with changement=1 on that same cycle only.
REQ-020 Total latency from a stable button edge at the pin to the new dMax SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, +/-1.
REQ-021 Outputs SHALL satisfy dMax>dMin at all times, so downstream (dMax+1)-dMin never underflows.

Reset
REQ-022 While rst_n=0, regardless of clk: FSM=D6, dMin=1, dMax=6, changement=0, synchronizers, accepted levels and all counters = 0.
REQ-023 After rst_n deasserts with a button already held, that press SHALL be debounced and produce exactly one event (accepted level starts at 0); a reset asserted mid-debounce SHALL discard the pending count.

Configuration
REQ-024 With macro SELECTEUR_AUTO_REPEAT_EN defined, a button whose accepted level stays 1 SHALL produce an additional press event every REPEAT_CYCLES cycles after its initial event, until release; the repeat counter resets on release, on reset, and when both accepted levels are 1 (no repeat then).
REQ-025 Without SELECTEUR_AUTO_REPEAT_EN, the repeat counter and REPEAT_CYCLES logic SHALL be absent and a held button SHALL produce exactly one event.

Verification (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32 on bench)
REQ-026 Reset, then idle 50 cycles -> dMin=1, dMax=6, changement never 1.
REQ-027 Hold btnSuiv 20 cycles once -> dMax 6->8, one changement pulse, event at cycle 2+8+1 (+/-1) after the edge.
REQ-028 btnSuiv glitch of 1-7 cycles, repeated 10 times -> dMax unchanged, no changement.
REQ-029 From reset, 5 btnSuiv presses -> dMax 8,10,12,20,100, sixth -> 4; then 1 btnPrec -> 100.
REQ-030 Both buttons pressed simultaneously (same cycle) -> no state change, no changement; rst_n pulsed low mid-debounce of btnPrec -> dMax=6 and no event from that press until re-debounced.
REQ-031 With SELECTEUR_AUTO_REPEAT_EN: hold btnSuiv 100 cycles -> events at ~11, 43, 75 -> dMax 8,10,12; without macro -> single event, dMax=8.

Source files
------------

// File: rtl/selecteur_type_de.sv
// rtl/selecteur_type_de.sv - die-type selector: two debounced buttons step through D4..D100.
// Optional build macro SELECTEUR_AUTO_REPEAT_EN adds auto-repeat on held buttons.

module selecteur_type_de_bouton #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
`ifdef SELECTEUR_AUTO_REPEAT_EN
  input  logic bloque,
`endif
  output logic niveau,
  output logic evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          front;

  // The counter only advances while the synchronized level disagrees with
  // the accepted one and is cleared on acceptance, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      niveau <= 1'b0;
      cnt    <= '0;
      front  <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      front <= 1'b0;
      if (s2 == niveau) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        niveau <= s2;
        cnt    <= '0;
        front  <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SELECTEUR_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep;
  logic          rep_evt;

  // Repeat stops as soon as the pin is seen released, not only once the
  // release itself has been debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep     <= '0;
      rep_evt <= 1'b0;
    end else begin
      rep_evt <= 1'b0;
      if (!niveau || !s2 || bloque) begin
        rep <= '0;
      end else if (rep >= REP_LAST) begin
        rep     <= '0;
        rep_evt <= 1'b1;
      end else begin
        rep <= rep + 1'b1;
      end
    end
  end

  assign evt = front | rep_evt;
`else
  assign evt = front;
`endif

endmodule

module selecteur_type_de #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnSuiv,
  input  logic       btnPrec,
  output logic [6:0] dMin,
  output logic [6:0] dMax,
  output logic       changement
);

  typedef enum logic [2:0] {D4, D6, D8, D10, D12, D20, D100} etat_t;

  etat_t etat;
  logic  niv_suiv;
  logic  niv_prec;
  logic  evt_suiv;
  logic  evt_prec;

  selecteur_type_de_bouton #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_suiv (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btnSuiv),
`ifdef SELECTEUR_AUTO_REPEAT_EN
    .bloque(niv_prec),
`endif
    .niveau(niv_suiv),
    .evt   (evt_suiv)
  );

  selecteur_type_de_bouton #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_prec (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btnPrec),
`ifdef SELECTEUR_AUTO_REPEAT_EN
    .bloque(niv_suiv),
`endif
    .niveau(niv_prec),
    .evt   (evt_prec)
  );

`ifndef SELECTEUR_AUTO_REPEAT_EN
  logic niv_inutile;
  assign niv_inutile = niv_suiv & niv_prec;
`endif

  function automatic etat_t suivant(input etat_t e);
    case (e)
      D4:      suivant = D6;
      D6:      suivant = D8;
      D8:      suivant = D10;
      D10:     suivant = D12;
      D12:     suivant = D20;
      D20:     suivant = D100;
      default: suivant = D4;
    endcase
  endfunction

  function automatic etat_t precedent(input etat_t e);
    case (e)
      D4:      precedent = D100;
      D6:      precedent = D4;
      D8:      precedent = D6;
      D10:     precedent = D8;
      D12:     precedent = D10;
      D20:     precedent = D12;
      default: precedent = D20;
    endcase
  endfunction

  function automatic logic [6:0] face_max(input etat_t e);
    case (e)
      D4:      face_max = 7'd4;
      D6:      face_max = 7'd6;
      D8:      face_max = 7'd8;
      D10:     face_max = 7'd10;
      D12:     face_max = 7'd12;
      D20:     face_max = 7'd20;
      default: face_max = 7'd100;
    endcase
  endfunction

  // Simultaneous events cancel: state, outputs and changement all hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      etat       <= D6;
      dMin       <= 7'd1;
      dMax       <= 7'd6;
      changement <= 1'b0;
    end else begin
      dMin       <= 7'd1;
      changement <= 1'b0;
      if (evt_suiv && !evt_prec) begin
        etat       <= suivant(etat);
        dMax       <= face_max(suivant(etat));
        changement <= 1'b1;
      end else if (evt_prec && !evt_suiv) begin
        etat       <= precedent(etat);
        dMax       <= face_max(precedent(etat));
        changement <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_selecteur_type_de.sv
// tb/tb_selecteur_type_de.sv - directed bench for selecteur_type_de (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32).

module tb_selecteur_type_de;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btnSuiv = 1'b0;
  logic       btnPrec = 1'b0;
  logic [6:0] dMin;
  logic [6:0] dMax;
  logic       changement;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_chg = 0;
  int last_chg = 0;
  int inv_bad = 0;

  always #5 clk = ~clk;

  selecteur_type_de #(
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btnSuiv   (btnSuiv),
    .btnPrec   (btnPrec),
    .dMin      (dMin),
    .dMax      (dMax),
    .changement(changement)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (changement === 1'b1) begin
      n_chg++;
      last_chg = cyc;
    end
    if (rst_n && !(dMax > dMin)) inv_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic appui(input bit s, input bit p, input int hold, input int rel);
    btnSuiv = s;
    btnPrec = p;
    tick(hold);
    btnSuiv = 1'b0;
    btnPrec = 1'b0;
    tick(rel);
  endtask

  task automatic reinit();
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  int exp_seq [6] = '{8, 10, 12, 20, 100, 4};
  int snap;
  int snap2;
  int t0;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_dmin", dMin, 1);
    check("reset_dmax", dMax, 6);
    check("reset_chg", changement, 0);
    tick(3);
    rst_n = 1'b1;

    tick(50);
    @(negedge clk);
    check("idle_dmin", dMin, 1);
    check("idle_dmax", dMax, 6);
    check("idle_no_chg", n_chg, 0);

    tick(1);
    t0 = cyc;
    appui(1, 0, 20, 20);
    @(negedge clk);
    check("press_dmax", dMax, 8);
    check("press_one_pulse", n_chg, 1);
    check("press_latency_in_10_12", (last_chg - t0 >= 10) && (last_chg - t0 <= 12), 1);

    for (int i = 0; i < 10; i++) appui(1, 0, 1 + (i % 7), 12);
    @(negedge clk);
    check("glitch_dmax", dMax, 8);
    check("glitch_no_chg", n_chg, 1);

    reinit();
    @(negedge clk);
    check("seq_start_dmax", dMax, 6);
    snap = n_chg;
    for (int i = 0; i < 6; i++) begin
      appui(1, 0, 15, 15);
      @(negedge clk);
      check($sformatf("seq_suiv_%0d", i), dMax, exp_seq[i]);
    end
    appui(0, 1, 15, 15);
    @(negedge clk);
    check("seq_prec_wrap", dMax, 100);
    check("seq_dmin", dMin, 1);
    check("seq_pulses", n_chg - snap, 7);

    snap = n_chg;
    appui(1, 1, 15, 15);
    @(negedge clk);
    check("both_dmax", dMax, 100);
    check("both_no_chg", n_chg - snap, 0);

    btnPrec = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midrst_async_dmax", dMax, 6);
    tick(2);
    rst_n = 1'b1;
    snap2 = n_chg;
    tick(6);
    @(negedge clk);
    check("midrst_pending_dmax", dMax, 6);
    check("midrst_pending_no_chg", n_chg - snap2, 0);
    tick(10);
    btnPrec = 1'b0;
    tick(15);
    @(negedge clk);
    check("midrst_redebounced_dmax", dMax, 4);
    check("midrst_one_event", n_chg - snap2, 1);

    reinit();
    snap = n_chg;
    btnSuiv = 1'b1;
    tick(100);
    btnSuiv = 1'b0;
    tick(20);
    @(negedge clk);
`ifdef SELECTEUR_AUTO_REPEAT_EN
    check("hold_dmax", dMax, 12);
    check("hold_events", n_chg - snap, 3);
`else
    check("hold_dmax", dMax, 8);
    check("hold_events", n_chg - snap, 1);
`endif

    check("dmax_gt_dmin", inv_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
